riscv_writeback: RTL

//  Write side of the register file: sole driver of its rd/wen/data write port.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/riscv_load_align.sv | 42 ++++
 rtl/riscv_writeback.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared widths and load funct3 encodings for the writeback slice.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load formatter: selects the byte/half lane, extends it, flags misaligned or illegal loads.
module riscv_load_align
    import riscv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [2:0]   i_funct3,
    input  logic [1:0]   i_addr_lo,
    input  logic [W-1:0] i_rdata,
    output logic         o_err,
    output logic [W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_err  = 1'b0;
        o_data = '0;
        case (i_funct3)
            F3_LB:  o_data = {{(W-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(W-8){1'b0}}, w_byte};
            F3_LH: begin
                o_err  = i_addr_lo[0];
                o_data = {{(W-16){w_half[15]}}, w_half};
            end
            F3_LHU: begin
                o_err  = i_addr_lo[0];
                o_data = {{(W-16){1'b0}}, w_half};
            end
            F3_LW: begin
                o_err  = (i_addr_lo != 2'b00);
                o_data = i_rdata;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_writeback.sv
// Register-file write port: load-priority arbiter, registered write, pending-destination scoreboard.
// Optional forwarding outputs enabled by defining RISCV_WB_BYPASS_EN.
module riscv_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic [4:0]      rd,
    output logic            wen,
    output logic [XLEN-1:0] data,
    output logic            ld_err
`ifdef RISCV_WB_BYPASS_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    logic            w_ld_err;
    logic [XLEN-1:0] w_ld_data;
    logic            w_alu_acc;
    logic            w_acc;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_sel_err;
    logic            w_wr;
    logic [NREGS-1:0] w_pend_nxt;

    logic [4:0]       r_rd;
    logic             r_wen;
    logic [XLEN-1:0]  r_data;
    logic             r_err;
    logic             r_done;
    logic [NREGS-1:0] r_pend;

    riscv_load_align #(.W(XLEN)) u_align (
        .i_funct3  (ld_funct3),
        .i_addr_lo (ld_addr_lo),
        .i_rdata   (ld_rdata),
        .o_err     (w_ld_err),
        .o_data    (w_ld_data)
    );

    assign ld_ready  = 1'b1;
    assign alu_ready = !rst && !ld_valid;

    always_comb begin
        w_alu_acc  = alu_valid && alu_ready;
        w_acc      = ld_valid || w_alu_acc;
        w_sel_rd   = ld_valid ? ld_rd : alu_rd;
        w_sel_data = ld_valid ? w_ld_data : alu_data;
        w_sel_err  = ld_valid && w_ld_err;
        w_wr       = w_acc && !w_sel_err && (w_sel_rd != 5'd0);
    end

    // r_done marks any accepted result (write, x0 or error) so its pending bit retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= '0;
            r_wen  <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_wen  <= w_wr;
            r_err  <= w_sel_err;
            r_done <= w_acc;
            if (w_acc)
                r_rd <= w_sel_rd;
            if (w_acc && !w_sel_err)
                r_data <= w_sel_data;
        end
    end

    // Set is applied after clear so a same-edge re-issue keeps the register pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_done)
            w_pend_nxt[r_rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            w_pend_nxt[issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pend <= '0;
        else
            r_pend <= w_pend_nxt;
    end

    assign busy_rs1 = r_pend[q_rs1] && (q_rs1 != 5'd0);
    assign busy_rs2 = r_pend[q_rs2] && (q_rs2 != 5'd0);

    assign rd     = r_rd;
    assign wen    = r_wen;
    assign data   = r_data;
    assign ld_err = r_err;

`ifdef RISCV_WB_BYPASS_EN
    assign fwd_valid = w_wr;
    assign fwd_rd    = w_sel_rd;
    assign fwd_data  = w_sel_data;
`endif

endmodule
